// File: rtl/jstk_pkg.sv
// Shared definitions for the PmodJSTK reader: FSM state encoding, frame
// geometry and the command byte that carries the LED bits.
`timescale 1ns/1ps
package jstk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_DONE,
        ST_WAIT
    } jstk_state_t;

    localparam int         JSTK_NUM_BYTES = 5;
    localparam logic [5:0] JSTK_LED_CMD   = 6'b100000;

    // Only the first byte of a frame carries the LED command; the rest are zero.
    function automatic logic [7:0] jstk_tx_byte(input logic first, input logic [1:0] led);
        return first ? {JSTK_LED_CMD, led} : 8'h00;
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// One 8-bit SPI mode-0 exchange, MSB first.
//   clk, clr      : system clock, async active-low reset
//   start         : one-cycle request; tx_data is captured on that edge
//   tx_data       : byte to send
//   miso          : already-synchronised serial input
//   done          : high during the final clk cycle of the exchange (comb)
//   rx_data       : received byte, complete while done is high
//   sclk, mosi    : SPI clock (idle low) and data out
`timescale 1ns/1ps
module spi_byte_shifter
    import jstk_pkg::*;
#(
    parameter int SCLK_HALF = 400
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       miso,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       sclk,
    output logic       mosi
);

    localparam int               HALF_W   = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [HALF_W-1:0] HALF_MAX = HALF_W'(SCLK_HALF - 1);

    logic              busy;
    logic [HALF_W-1:0] half_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        tx_sh;
    logic [7:0]        rx_sh;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            busy     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= tx_data[7];
            tx_sh    <= {tx_data[6:0], 1'b0};
            half_cnt <= HALF_MAX;
            bit_cnt  <= 3'd7;
        end else if (busy) begin
            if (half_cnt != '0) begin
                half_cnt <= half_cnt - 1'b1;
            end else begin
                half_cnt <= HALF_MAX;
                if (!sclk) begin
                    // rising edge: sample the slave
                    sclk  <= 1'b1;
                    rx_sh <= {rx_sh[6:0], miso};
                end else begin
                    // falling edge: next bit goes out while sclk is low
                    sclk <= 1'b0;
                    if (bit_cnt == 3'd0) begin
                        busy <= 1'b0;
                        mosi <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                        mosi    <= tx_sh[7];
                        tx_sh   <= {tx_sh[6:0], 1'b0};
                    end
                end
            end
        end
    end

    // Last cycle of bit 7's high half; lets the caller move on the same edge sclk falls.
    assign done    = busy && sclk && (half_cnt == '0) && (bit_cnt == 3'd0);
    assign rx_data = rx_sh;

endmodule

// File: rtl/joystick_spi_reader.sv
// Polls one PmodJSTK over SPI and presents stick position and buttons as
// registered values that all update together, with a one-cycle valid pulse.
//   clk, clr        : system clock, async active-low reset
//   en              : poll enable, looked at only while idle
//   led             : Pmod LED command, latched when a frame starts
//   ss, sclk, mosi  : SPI master outputs (ss active-low, mode 0)
//   miso            : SPI data from the Pmod (asynchronous)
//   joy_x, joy_y    : 10-bit positions
//   btn             : {btn2, btn1, stick_btn}
//   valid           : pulses when joy_x/joy_y/btn are updated
//
// state | meaning
// IDLE  | ss high, waiting for en
// SETUP | ss low, settling time before the first sclk
// SHIFT | one byte exchange in progress
// GAP   | ss low, sclk low between bytes
// DONE  | ss high, outputs loaded, valid high (one cycle)
// WAIT  | ss high, poll interval before returning to IDLE
`timescale 1ns/1ps
module joystick_spi_reader
    import jstk_pkg::*;
#(
    parameter int SCLK_HALF = 400,
    parameter int SS_SETUP  = 1500,
    parameter int BYTE_GAP  = 1000,
    parameter int POLL_GAP  = 1000000,
    parameter int RESET_POS = 512
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] led,
    output logic       ss,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic [9:0] joy_x,
    output logic [9:0] joy_y,
    output logic [2:0] btn,
    output logic       valid
);

    localparam int T_MAX = (POLL_GAP > SS_SETUP) ?
                           ((POLL_GAP > BYTE_GAP) ? POLL_GAP : BYTE_GAP) :
                           ((SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP);
    localparam int CNT_W = $clog2(T_MAX + 1);

    jstk_state_t      state, next_state;
    logic [CNT_W-1:0] cnt, cnt_val;
    logic             cnt_load;
    logic [2:0]       byte_idx;
    logic [1:0]       led_q;
    logic [7:0]       rx0, rx2;
    logic [1:0]       rx1, rx3;
    logic             miso_m, miso_s;
    logic             start, shift_done, last_byte;
    logic [7:0]       tx_data, rx_data;

    spi_byte_shifter #(.SCLK_HALF(SCLK_HALF)) u_shifter (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .tx_data (tx_data),
        .miso    (miso_s),
        .done    (shift_done),
        .rx_data (rx_data),
        .sclk    (sclk),
        .mosi    (mosi)
    );

    assign last_byte = (byte_idx == 3'(JSTK_NUM_BYTES - 1));
    assign tx_data   = jstk_tx_byte(state == ST_SETUP, led_q);

    always_comb begin
        next_state = state;
        start      = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        case (state)
            ST_IDLE: if (en) begin
                next_state = ST_SETUP;
                cnt_load   = 1'b1;
                cnt_val    = CNT_W'(SS_SETUP - 1);
            end
            ST_SETUP: if (cnt == '0) begin
                next_state = ST_SHIFT;
                start      = 1'b1;
            end
            ST_SHIFT: if (shift_done) begin
                if (last_byte) begin
                    next_state = ST_DONE;
                end else begin
                    next_state = ST_GAP;
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(BYTE_GAP - 1);
                end
            end
            ST_GAP: if (cnt == '0) begin
                next_state = ST_SHIFT;
                start      = 1'b1;
            end
            ST_DONE: begin
                next_state = ST_WAIT;
                cnt_load   = 1'b1;
                cnt_val    = CNT_W'(POLL_GAP - 1);
            end
            ST_WAIT: if (cnt == '0) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt      <= '0;
            byte_idx <= '0;
            led_q    <= '0;
            rx0      <= '0;
            rx1      <= '0;
            rx2      <= '0;
            rx3      <= '0;
            miso_m   <= 1'b0;
            miso_s   <= 1'b0;
        end else begin
            miso_m <= miso;
            miso_s <= miso_m;

            if (cnt_load)          cnt <= cnt_val;
            else if (cnt != '0)    cnt <= cnt - 1'b1;

            if (state == ST_IDLE && en) begin
                byte_idx <= '0;
                led_q    <= led;
            end else if (state == ST_GAP && cnt == '0) begin
                byte_idx <= byte_idx + 1'b1;
            end

            if (state == ST_SHIFT && shift_done) begin
                case (byte_idx)
                    3'd0:    rx0 <= rx_data;
                    3'd1:    rx1 <= rx_data[1:0];
                    3'd2:    rx2 <= rx_data;
                    3'd3:    rx3 <= rx_data[1:0];
                    default: ;
                endcase
            end
        end
    end

    // Outputs load on the edge into DONE, so they are visible together with valid.
    // Byte 4 is taken straight from the shifter since it is never stored.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ss    <= 1'b1;
            valid <= 1'b0;
            joy_x <= 10'(RESET_POS);
            joy_y <= 10'(RESET_POS);
            btn   <= '0;
        end else begin
            ss    <= !(next_state == ST_SETUP || next_state == ST_SHIFT || next_state == ST_GAP);
            valid <= (next_state == ST_DONE);
            if (state == ST_SHIFT && shift_done && last_byte) begin
                joy_x <= {rx1, rx0};
                joy_y <= {rx3, rx2};
                btn   <= rx_data[2:0];
            end
        end
    end

endmodule

// File: tb/tb_joystick_spi_reader.sv
`timescale 1ns/1ps
module tb_joystick_spi_reader;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       en  = 1'b0;
    logic [1:0] led = 2'b00;
    logic       ss, sclk, mosi, miso;
    logic [9:0] joy_x, joy_y;
    logic [2:0] btn;
    logic       valid;

    always #5 clk = ~clk;

    joystick_spi_reader #(
        .SCLK_HALF (4),
        .SS_SETUP  (10),
        .BYTE_GAP  (6),
        .POLL_GAP  (50),
        .RESET_POS (512)
    ) dut (
        .clk   (clk),
        .clr   (clr),
        .en    (en),
        .led   (led),
        .ss    (ss),
        .sclk  (sclk),
        .mosi  (mosi),
        .miso  (miso),
        .joy_x (joy_x),
        .joy_y (joy_y),
        .btn   (btn),
        .valid (valid)
    );

    // PmodJSTK slave model: mode 0, MSB first, 5 bytes per frame
    logic [7:0] resp [5];
    logic [7:0] cap  [5];
    logic [7:0] s_tx = 8'h00;
    logic [7:0] s_rx = 8'h00;
    int         s_bit = 0;
    int         s_byte = 0;
    logic       in_frame = 1'b0;
    logic       sclk_prev = 1'b0;

    assign miso = s_tx[7];

    always @(ss or sclk) begin
        if (ss) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            in_frame = 1'b1;
            s_byte   = 0;
            s_bit    = 0;
            s_tx     = resp[0];
        end else if (sclk && !sclk_prev) begin
            s_rx = {s_rx[6:0], mosi};
            s_bit++;
            if (s_bit == 8 && s_byte < 5) cap[s_byte] = s_rx;
        end else if (!sclk && sclk_prev) begin
            if (s_bit == 8) begin
                s_bit = 0;
                s_byte++;
                s_tx = (s_byte < 5) ? resp[s_byte] : 8'h00;
            end else begin
                s_tx = {s_tx[6:0], 1'b0};
            end
        end
        sclk_prev = sclk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [39:0] resp;
        logic [1:0]  led;
        logic        mid_change;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  b;
        logic [7:0]  cmd;
    } vec_t;

    vec_t vecs [4];

    localparam int TXN_CYC = 10 + 320 + 24;
    localparam int PERIOD  = TXN_CYC + 1 + 50 + 1;

    // Starts a frame from IDLE at a negedge; drops en once ss falls.
    task automatic run_txn(input logic [39:0] r, input logic [1:0] l, input logic mid,
                           output int fall_n, output int done_n, output int valid_len);
        for (int i = 0; i < 5; i++) begin
            resp[i] = r[39-8*i -: 8];
            cap[i]  = 8'hEE;
        end
        led    = l;
        en     = 1'b1;
        fall_n = 0;
        while (ss && fall_n < 100) begin
            @(negedge clk);
            fall_n++;
        end
        en     = 1'b0;
        done_n = 0;
        while (!valid && done_n < 2000) begin
            @(negedge clk);
            done_n++;
            if (mid && done_n == 100) led = ~l;
        end
        valid_len = 0;
        while (valid && valid_len < 10) begin
            @(negedge clk);
            valid_len++;
        end
    endtask

    initial begin
        int fall_n, done_n, valid_len, cnt, vcnt, n;
        logic prev;

        vecs[0] = '{40'h34_02_CD_01_05, 2'b00, 1'b0, 10'h234, 10'h1CD, 3'b101, 8'h80};
        vecs[1] = '{40'hFF_FF_00_FC_F8, 2'b01, 1'b0, 10'h3FF, 10'h000, 3'b000, 8'h81};
        vecs[2] = '{40'h12_03_AB_02_07, 2'b10, 1'b1, 10'h312, 10'h2AB, 3'b111, 8'h82};
        vecs[3] = '{40'hFF_FF_FF_FF_FF, 2'b11, 1'b0, 10'h3FF, 10'h3FF, 3'b111, 8'h83};

        // reset
        clr = 1'b0;
        #100;
        chk("reset ss", ss, 1);
        chk("reset sclk", sclk, 0);
        chk("reset mosi", mosi, 0);
        chk("reset joy_x", joy_x, 512);
        chk("reset joy_y", joy_y, 512);
        chk("reset btn", btn, 0);
        chk("reset valid", valid, 0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);

        // table-driven frames
        foreach (vecs[k]) begin
            run_txn(vecs[k].resp, vecs[k].led, vecs[k].mid_change, fall_n, done_n, valid_len);
            chk($sformatf("v%0d ss fall latency", k), fall_n, 1);
            chk($sformatf("v%0d cycles to done", k), done_n, TXN_CYC);
            chk($sformatf("v%0d valid width", k), valid_len, 1);
            chk($sformatf("v%0d joy_x", k), joy_x, vecs[k].x);
            chk($sformatf("v%0d joy_y", k), joy_y, vecs[k].y);
            chk($sformatf("v%0d btn", k), btn, vecs[k].b);
            chk($sformatf("v%0d mosi byte0", k), cap[0], vecs[k].cmd);
            chk($sformatf("v%0d mosi bytes1-4", k), {cap[1], cap[2], cap[3], cap[4]}, 0);
            repeat (60) @(negedge clk);
        end

        // reset in the middle of byte 2
        for (int i = 0; i < 5; i++) resp[i] = 8'h00;
        led = 2'b00;
        en  = 1'b1;
        n   = 0;
        while (ss && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("abort ss fell", ss, 0);
        en = 1'b0;
        repeat (10 + 2 * 70 + 20) @(negedge clk);
        #2;
        clr = 1'b0;
        #1;
        chk("abort ss async", ss, 1);
        chk("abort sclk async", sclk, 0);
        chk("abort joy_x", joy_x, 512);
        chk("abort joy_y", joy_y, 512);
        chk("abort btn", btn, 0);
        @(negedge clk);
        clr = 1'b1;
        repeat (3) @(negedge clk);
        run_txn(vecs[0].resp, 2'b01, 1'b0, fall_n, done_n, valid_len);
        chk("post-abort ss fall latency", fall_n, 1);
        chk("post-abort cycles to done", done_n, TXN_CYC);
        chk("post-abort joy_x", joy_x, 10'h234);
        chk("post-abort joy_y", joy_y, 10'h1CD);
        chk("post-abort btn", btn, 3'b101);
        chk("post-abort mosi byte0", cap[0], 8'h81);
        repeat (60) @(negedge clk);

        // en held low: nothing happens
        en   = 1'b0;
        cnt  = 0;
        vcnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (!ss) cnt++;
            if (valid) vcnt++;
        end
        chk("en low ss activity", cnt, 0);
        chk("en low valid pulses", vcnt, 0);
        chk("en low joy_x hold", joy_x, 10'h234);

        // en held high: periodic polling
        for (int i = 0; i < 5; i++) resp[i] = vecs[2].resp[39-8*i -: 8];
        en = 1'b1;
        n  = 0;
        while (ss && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("poll first fall", n, 1);
        for (int p = 0; p < 2; p++) begin
            n    = 0;
            vcnt = 0;
            prev = 1'b0;
            while (n < 2000) begin
                @(negedge clk);
                n++;
                if (valid) vcnt++;
                if (prev && !ss) break;
                prev = ss;
            end
            chk($sformatf("poll%0d period", p), n, PERIOD);
            chk($sformatf("poll%0d valid count", p), vcnt, 1);
            chk($sformatf("poll%0d joy_x", p), joy_x, 10'h312);
        end
        en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
